apb_gpio_bank: RTL and testbench
================================

# apb_gpio_bank

APB slave holding one 8-bit GPIO bank: output data, direction, synchronised input sampling, and optional edge-triggered interrupts. One instance sits downstream of the SPI-to-APB bridge per bank and connects to one bit of the bridge's `b_psel` vector. It shares `b_paddr`, `b_pwrite`, `b_penable` and `b_pwdata` with the other instances. It returns `prdata`/`pready` to the bridge and drives the chip's GPIO pads.

## Interface
- `DATA_WIDTH`, 8: register and GPIO width.
- `ADDR_WIDTH`, 3: APB address width. Eight word offsets.
- `pclk` input, 1: the bridge's `b_pclk`. Sole clock; all logic on its rising edge.
- `reset` input, 1: synchronous, active-high. Sampled on `pclk` rising edge.
- `psel` input, 1: this bank's bit of `b_psel`.
- `penable` input, 1: APB enable.
- `pwrite` input, 1: 1 means write, 0 means read.
- `paddr` input, ADDR_WIDTH: register offset.
- `pwdata` input, DATA_WIDTH: write data.
- `prdata` output, DATA_WIDTH: registered read data.
- `pready` output, 1: slave ready. Registered.
- `gpio_in` input, DATA_WIDTH: asynchronous pad inputs.
- `gpio_out` output, DATA_WIDTH: pad output values.
- `gpio_oe` output, DATA_WIDTH: per-pin output enable. 1 means drive.
- `irq` output, 1: level interrupt.

## Operation
- Register map:
  - 0 OUT: RW.
  - 1 DIR: RW. Drives `gpio_oe`.
  - 2 IN: RO. Synchronised `gpio_in`.
  - 3 IEN: RW. Interrupt enable.
  - 4 ISTAT: RW1C. Sticky edge flags.
  - 5 EDGE: RW. Per bit, 1 means rising edge, 0 means falling edge.
  - 6 SET: WO. OUT |= pwdata.
  - 7 CLR: WO. OUT &= ~pwdata.
- Reads of WO offsets return 0.
- Writes to RO offsets are ignored.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE to SETUP: `psel` and not `penable`.
  - SETUP to ACCESS: `psel` and `penable`. This edge is the only commit point.
    - Write: the register updates on this edge.
    - Read: `prdata` loads on this edge.
  - SETUP to IDLE: `psel` drops.
  - ACCESS stays in ACCESS while `psel` and `penable` are held. The bridge holds `penable` high indefinitely, so no re-commit happens.
  - ACCESS to SETUP: `psel` and not `penable`.
  - ACCESS to IDLE: not `psel`.
  - IDLE with `psel` and `penable` both high (no setup phase): go to ACCESS with no commit and no `prdata` update.
  - `penable` without `psel`: ignored in every state.
- `pready` is held high in all states. Zero wait states. The bridge only launches transfers while `pready` is high.
- `prdata` holds its last value outside commits.
- Input path:
  - 2-flop synchroniser feeds `in_s`, which is readable at offset 2.
  - A 1-flop delayed copy `in_d` is kept for edge detection.
  - rise = in_s & ~in_d; fall = ~in_s & in_d.
  - evt = EDGE ? rise : fall, per bit.
- ISTAT:
  - Next value = (ISTAT & ~w1c_mask) | evt.
  - If an event and a W1C on the same bit coincide, set wins.
  - Events are captured regardless of IEN.
- `irq` = |(ISTAT & IEN). Combinational from registers only.

## Timing
- Reset values: all registers 0, `gpio_out` 0, `gpio_oe` 0, `prdata` 0, `pready` 1, `irq` 0, FSM in IDLE, synchroniser flops 0.
- Reset mid-transfer: the FSM returns to IDLE and no commit occurs in that cycle.
- Write latency: `gpio_out`/`gpio_oe` change on the SETUP-to-ACCESS edge itself, with zero added cycles.
- Read latency: `prdata` is valid from the SETUP-to-ACCESS edge until the next read commit.
- Input latency:
  - A `gpio_in` change is visible in IN after 2 `pclk` edges.
  - ISTAT sets on the 3rd edge.
  - `irq` rises in the same cycle as ISTAT.
- Input pulses shorter than one `pclk` period may be missed. This is acceptable.

## Configuration
- `GPIO_IRQ_EN` defined: IEN, ISTAT, EDGE, the edge detector and `irq` are implemented as above.
- `GPIO_IRQ_EN` undefined:
  - Offsets 3–5 read 0 and ignore writes.
  - `in_d` and the edge logic are removed.
  - `irq` is tied to 0.
  - All other behaviour is identical.

## Structure
- `gpio_bank_pkg` holds:
  - Register offset constants: OFF_OUT, OFF_DIR, OFF_IN, OFF_IEN, OFF_ISTAT, OFF_EDGE, OFF_SET, OFF_CLR.
  - The FSM state type and encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2.
- One sub-module, `gpio_sync_edge`:
  - Parameterised by width.
  - Contains the 2-flop synchroniser, delay flop and rise/fall outputs.
  - Uses the same `pclk`/`reset`.

## Test plan
- Reset, then read all 8 offsets. Required: every read returns 0x00; `pready`=1; `irq`=0; `gpio_oe`=0x00.
- Write OUT=0xA5 and DIR=0x0F, then read both back. Required: `gpio_out`=0xA5 and `gpio_oe`=0x0F on the commit edge; reads return 0xA5 and 0x0F.
- Starting from OUT=0xA5, write SET=0x50 then CLR=0x05. Required: `gpio_out`=0xF5, then 0xF0; reads of offsets 6 and 7 return 0.
- Hold `psel`/`penable` high for 10 cycles after one write of OUT=0x01, with `pwdata` changed to 0xFF mid-hold. Required: OUT stays 0x01, showing a single commit.
- Set EDGE=0x01 and IEN=0x01, then drive `gpio_in[0]` 0→1. Required: IN[0] reads 1 after 2 edges; ISTAT=0x01 and `irq`=1 on the 3rd edge. Then W1C ISTAT=0x01 in the same cycle as a new rising event on bit 0. Required: ISTAT stays 0x01.
- Assert `reset` during the SETUP phase of a write OUT=0xFF. Required: OUT=0x00, FSM in IDLE, no commit.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the APB GPIO bank: register offsets and the APB slave state encoding.
// Pure declarations: no latency or backpressure of its own.
package gpio_bank_pkg;

   localparam int OFF_OUT   = 0;
   localparam int OFF_DIR   = 1;
   localparam int OFF_IN    = 2;
   localparam int OFF_IEN   = 3;
   localparam int OFF_ISTAT = 4;
   localparam int OFF_EDGE  = 5;
   localparam int OFF_SET   = 6;
   localparam int OFF_CLR   = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchroniser plus, with GPIO_IRQ_EN, a delay flop giving per-bit rise/fall pulses.
// in_s_o lags the pad by 2 edges, rise/fall assert for one cycle after that; never stalls.
module gpio_sync_edge
   import gpio_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] in_s_o
`ifdef GPIO_IRQ_EN
   ,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
`endif
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge pclk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign in_s_o = sync_q;

`ifdef GPIO_IRQ_EN
   logic [WIDTH-1:0] dly_q;

   always_ff @(posedge pclk) begin
      if (reset) begin
         dly_q <= '0;
      end else begin
         dly_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;
`endif

endmodule

// File: rtl/apb_gpio_bank.sv
// APB slave for one GPIO bank (OUT/DIR/IN/SET/CLR; IEN/ISTAT/EDGE and irq only when GPIO_IRQ_EN is defined).
// Writes and reads commit on the SETUP->ACCESS edge with zero wait states; pready is always high.
module apb_gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   apb_state_e            state_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  pready_q;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [DATA_WIDTH-1:0] dir_q, dir_d;
   logic [DATA_WIDTH-1:0] in_s;
   logic [DATA_WIDTH-1:0] rd_dat;
   logic                  commit;
   logic                  wr_en;
   logic                  rd_en;

   // A held ACCESS phase never re-commits; only the SETUP->ACCESS transition does.
   assign commit = (state_q == SETUP) && psel && penable;
   assign wr_en  = commit && pwrite;
   assign rd_en  = commit && !pwrite;

`ifdef GPIO_IRQ_EN
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] fall;

   gpio_sync_edge #(
      .WIDTH (DATA_WIDTH)
   ) u_sync (
      .pclk    (pclk),
      .reset   (reset),
      .async_i (gpio_in),
      .in_s_o  (in_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );
`else
   gpio_sync_edge #(
      .WIDTH (DATA_WIDTH)
   ) u_sync (
      .pclk    (pclk),
      .reset   (reset),
      .async_i (gpio_in),
      .in_s_o  (in_s)
   );
`endif

`ifdef GPIO_IRQ_EN
   logic [DATA_WIDTH-1:0] ien_q, ien_d;
   logic [DATA_WIDTH-1:0] istat_q, istat_d;
   logic [DATA_WIDTH-1:0] edge_q, edge_d;
   logic [DATA_WIDTH-1:0] evt;
   logic [DATA_WIDTH-1:0] w1c_mask;

   assign evt = (edge_q & rise) | (~edge_q & fall);

   // Events are OR-ed in after the clear so a coincident edge keeps its flag.
   always_comb begin
      ien_d    = ien_q;
      edge_d   = edge_q;
      w1c_mask = '0;
      if (wr_en) begin
         case (int'(paddr))
            OFF_IEN:   ien_d    = pwdata;
            OFF_EDGE:  edge_d   = pwdata;
            OFF_ISTAT: w1c_mask = pwdata;
            default:   ;
         endcase
      end
      istat_d = (istat_q & ~w1c_mask) | evt;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         ien_q   <= '0;
         istat_q <= '0;
         edge_q  <= '0;
      end else begin
         ien_q   <= ien_d;
         istat_q <= istat_d;
         edge_q  <= edge_d;
      end
   end

   assign irq = |(istat_q & ien_q);
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_dat = '0;
      case (int'(paddr))
         OFF_OUT:   rd_dat = out_q;
         OFF_DIR:   rd_dat = dir_q;
         OFF_IN:    rd_dat = in_s;
`ifdef GPIO_IRQ_EN
         OFF_IEN:   rd_dat = ien_q;
         OFF_ISTAT: rd_dat = istat_q;
         OFF_EDGE:  rd_dat = edge_q;
`endif
         default:   rd_dat = '0;
      endcase
   end

   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      if (wr_en) begin
         case (int'(paddr))
            OFF_OUT: out_d = pwdata;
            OFF_DIR: dir_d = pwdata;
            OFF_SET: out_d = out_q | pwdata;
            OFF_CLR: out_d = out_q & ~pwdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         out_q <= '0;
         dir_q <= '0;
      end else begin
         out_q <= out_d;
         dir_q <= dir_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q  <= IDLE;
         prdata_q <= '0;
         pready_q <= 1'b1;
      end else begin
         pready_q <= 1'b1;
         if (rd_en) begin
            prdata_q <= rd_dat;
         end
         case (state_q)
            IDLE: begin
               if (psel) begin
                  state_q <= penable ? ACCESS : SETUP;
               end
            end
            SETUP: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (penable) begin
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (!penable) begin
                  state_q <= SETUP;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign prdata   = prdata_q;
   assign pready   = pready_q;
   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Self-checking bench for apb_gpio_bank: read expectations queue up at stimulus time and are
// compared when prdata lands; pin and irq levels are checked directly at the falling edge.
module tb_apb_gpio_bank;
   import gpio_bank_pkg::*;

   logic       pclk = 1'b0;
   logic       reset;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic [7:0] gpio_oe;
   logic       irq;

   int err_cnt = 0;
   int chk_cnt = 0;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } rd_exp_t;

   rd_exp_t sb_q[$];

   always #5 pclk = ~pclk;

   apb_gpio_bank #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3)
   ) dut (
      .pclk     (pclk),
      .reset    (reset),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop();
      rd_exp_t e;
      if (sb_q.size() == 0) begin
         chk_cnt++;
         err_cnt++;
         $display("FAIL sb_empty: got read data 0x%0h, expected a queued entry", prdata);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, 32'(prdata), 32'(e.exp));
      end
   endtask

   // Called at a falling edge; returns at the falling edge just after the commit edge.
   task automatic apb_write(input int a, input logic [7:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'(a); pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input int a, input logic [7:0] exp, input string tag);
      rd_exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'(a);
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      sb_pop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish within 100us");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; gpio_in = '0;
      repeat (3) @(negedge pclk);
      reset = 1'b0;

      check_val("rst_pready", 32'(pready), 32'd1);
      check_val("rst_irq", 32'(irq), 32'd0);
      check_val("rst_oe", 32'(gpio_oe), 32'h00);
      check_val("rst_out", 32'(gpio_out), 32'h00);
      check_val("rst_prdata", 32'(prdata), 32'h00);
      check_val("rst_state", 32'(dut.state_q), 32'(IDLE));
      for (int i = 0; i < 8; i++) apb_read(i, 8'h00, $sformatf("rst_rd%0d", i));
      check_val("pready_after_rd", 32'(pready), 32'd1);

      apb_write(OFF_OUT, 8'hA5);
      check_val("wr_out_pin", 32'(gpio_out), 32'hA5);
      apb_write(OFF_DIR, 8'h0F);
      check_val("wr_dir_pin", 32'(gpio_oe), 32'h0F);
      check_val("out_kept", 32'(gpio_out), 32'hA5);
      apb_read(OFF_OUT, 8'hA5, "rd_out");
      apb_read(OFF_DIR, 8'h0F, "rd_dir");
      apb_write(OFF_IN, 8'hFF);
      apb_read(OFF_IN, 8'h00, "in_ro");

      apb_write(OFF_SET, 8'h50);
      check_val("set_pin", 32'(gpio_out), 32'hF5);
      apb_write(OFF_CLR, 8'h05);
      check_val("clr_pin", 32'(gpio_out), 32'hF0);
      apb_read(OFF_SET, 8'h00, "rd_set_wo");
      apb_read(OFF_CLR, 8'h00, "rd_clr_wo");
      apb_read(OFF_OUT, 8'hF0, "rd_out_setclr");

      // One commit, then a long held ACCESS with pwdata changing underneath it.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'(OFF_OUT); pwdata = 8'h01;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      check_val("hold_commit", 32'(gpio_out), 32'h01);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) pwdata = 8'hFF;
         @(negedge pclk);
      end
      check_val("hold_state", 32'(dut.state_q), 32'(ACCESS));
      check_val("hold_no_recommit", 32'(gpio_out), 32'h01);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      apb_read(OFF_OUT, 8'h01, "rd_out_hold");

`ifdef GPIO_IRQ_EN
      apb_write(OFF_EDGE, 8'h01);
      apb_write(OFF_IEN, 8'h01);
`else
      apb_write(OFF_IEN, 8'hFF);
      apb_write(OFF_ISTAT, 8'hFF);
      apb_write(OFF_EDGE, 8'hFF);
      apb_read(OFF_IEN, 8'h00, "noirq_ien");
      apb_read(OFF_ISTAT, 8'h00, "noirq_istat");
      apb_read(OFF_EDGE, 8'h00, "noirq_edge");
`endif
      // Pad rises together with a read whose commit is the 2nd edge: still old value.
      gpio_in = 8'h01;
      apb_read(OFF_IN, 8'h00, "in_at_2nd_edge");
      check_val("irq_before_3rd", 32'(irq), 32'd0);
      @(negedge pclk);
`ifdef GPIO_IRQ_EN
      check_val("irq_at_3rd", 32'(irq), 32'd1);
`else
      check_val("noirq_irq", 32'(irq), 32'd0);
`endif
      apb_read(OFF_IN, 8'h01, "in_sync");

`ifdef GPIO_IRQ_EN
      apb_read(OFF_ISTAT, 8'h01, "istat_rise");
      gpio_in = 8'h00;
      repeat (4) @(negedge pclk);
      check_val("irq_sticky", 32'(irq), 32'd1);
      gpio_in = 8'h01;
      @(negedge pclk);
      apb_write(OFF_ISTAT, 8'h01);
      check_val("irq_set_wins", 32'(irq), 32'd1);
      apb_read(OFF_ISTAT, 8'h01, "istat_set_wins");
      apb_write(OFF_ISTAT, 8'h01);
      check_val("irq_cleared", 32'(irq), 32'd0);
      apb_read(OFF_ISTAT, 8'h00, "istat_cleared");

      gpio_in = 8'h03;
      repeat (4) @(negedge pclk);
      gpio_in = 8'h01;
      repeat (4) @(negedge pclk);
      apb_read(OFF_ISTAT, 8'h02, "istat_fall");
      check_val("irq_masked", 32'(irq), 32'd0);
      apb_write(OFF_IEN, 8'h03);
      check_val("irq_unmasked", 32'(irq), 32'd1);
      apb_write(OFF_ISTAT, 8'h02);
      check_val("irq_fall_clr", 32'(irq), 32'd0);
`else
      gpio_in = 8'h00;
      repeat (4) @(negedge pclk);
      check_val("noirq_irq_fall", 32'(irq), 32'd0);
      apb_read(OFF_IN, 8'h00, "in_fall");
`endif

      // penable with psel low is not a transfer.
      psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 3'(OFF_OUT); pwdata = 8'hFF;
      repeat (2) @(negedge pclk);
      penable = 1'b0;
      check_val("penable_no_psel", 32'(gpio_out), 32'h01);
      check_val("penable_no_psel_st", 32'(dut.state_q), 32'(IDLE));

      // Reset lands on what would have been the commit edge.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'(OFF_OUT); pwdata = 8'hFF;
      @(negedge pclk);
      check_val("rst_mid_setup", 32'(dut.state_q), 32'(SETUP));
      penable = 1'b1;
      reset = 1'b1;
      @(negedge pclk);
      check_val("rst_mid_out", 32'(gpio_out), 32'h00);
      check_val("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
      check_val("rst_mid_oe", 32'(gpio_oe), 32'h00);
      check_val("rst_mid_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      @(negedge pclk);
      check_val("idle_to_access", 32'(dut.state_q), 32'(ACCESS));
      check_val("idle_to_access_out", 32'(gpio_out), 32'h00);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check_val("back_idle", 32'(dut.state_q), 32'(IDLE));
      apb_read(OFF_OUT, 8'h00, "rd_out_after_rst");
      apb_read(OFF_DIR, 8'h00, "rd_dir_after_rst");

      if (sb_q.size() != 0) begin
         chk_cnt++;
         err_cnt++;
         $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
